// File: rtl/pmem_arbiter_if.sv
// pmem_arbiter_if: bundles the three line-port buses around the arbiter.
//   icache side : i_pmem_read, i_pmem_address -> arbiter; i_pmem_rdata, i_pmem_resp <- arbiter
//   dcache side : d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata -> arbiter;
//                 d_pmem_rdata, d_pmem_resp <- arbiter
//   memory side : pmem_read, pmem_write, pmem_address, pmem_wdata <- arbiter;
//                 pmem_rdata, pmem_resp -> arbiter
// The slave modport is the arbiter's view; the master modport is the view of
// the surrounding caches and memory.
interface pmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;

  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  i_pmem_read, i_pmem_address,
    output i_pmem_rdata, i_pmem_resp,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output d_pmem_rdata, d_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output i_pmem_read, i_pmem_address,
    input  i_pmem_rdata, i_pmem_resp,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  d_pmem_rdata, d_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one physical-memory line port between the icache and
// the dcache. One 256-bit line read or write is in flight at a time; the
// winner's address, write line and operation are registered at grant and held
// on the memory port until pmem_resp. A dcache write-back is always followed by
// a one-cycle D_HOLD window in which the dcache gets first claim, so its line
// fill cannot be split off by an instruction fetch.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pmem_arbiter_if.slave carrying the icache, dcache and memory buses
module pmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  pmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    D_HOLD = 2'd3
  } state_t;

  state_t            state,      state_nxt;
  logic              op_write,   op_write_nxt;
  logic [ADDR_W-1:0] addr_q,     addr_nxt;
  logic [LINE_W-1:0] wdata_q,    wdata_nxt;
  logic              last_grant, last_grant_nxt;  // 0 = icache, 1 = dcache

  logic i_req;
  logic d_req;

  assign i_req = bus.i_pmem_read;
  assign d_req = bus.d_pmem_read | bus.d_pmem_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_write   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      last_grant <= 1'b0;
    end else begin
      state      <= state_nxt;
      op_write   <= op_write_nxt;
      addr_q     <= addr_nxt;
      wdata_q    <= wdata_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    op_write_nxt   = op_write;
    addr_nxt       = addr_q;
    wdata_nxt      = wdata_q;
    last_grant_nxt = last_grant;

    unique case (state)
      IDLE: begin
        // On a tie the requester that did not win last time is served; with
        // last_grant reset to I, the first tie after reset goes to D.
        if (d_req && (!i_req || !last_grant)) begin
          state_nxt      = D_BUSY;
          addr_nxt       = bus.d_pmem_address;
          wdata_nxt      = bus.d_pmem_wdata;
          op_write_nxt   = bus.d_pmem_write;  // write wins if both strobes are high
          last_grant_nxt = 1'b1;
        end else if (i_req) begin
          state_nxt      = I_BUSY;
          addr_nxt       = bus.i_pmem_address;
          op_write_nxt   = 1'b0;
          last_grant_nxt = 1'b0;
        end
      end

      I_BUSY: begin
        if (bus.pmem_resp) state_nxt = IDLE;
      end

      D_BUSY: begin
        // After a write-back the dcache usually issues its line fill next;
        // D_HOLD reserves one cycle for it.
        if (bus.pmem_resp) state_nxt = op_write ? D_HOLD : IDLE;
      end

      D_HOLD: begin
        // The dcache has priority here regardless of last_grant.
        if (d_req) begin
          state_nxt      = D_BUSY;
          addr_nxt       = bus.d_pmem_address;
          op_write_nxt   = bus.d_pmem_write;
          last_grant_nxt = 1'b1;
          if (bus.d_pmem_write) wdata_nxt = bus.d_pmem_wdata;
        end else if (i_req) begin
          state_nxt      = I_BUSY;
          addr_nxt       = bus.i_pmem_address;
          op_write_nxt   = 1'b0;
          last_grant_nxt = 1'b0;
        end else begin
          state_nxt      = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Memory strobes come straight from registered state, so a grant shows up
  // on the port one cycle after the request.
  assign bus.pmem_read    = (state == I_BUSY) | ((state == D_BUSY) & ~op_write);
  assign bus.pmem_write   = (state == D_BUSY) & op_write;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;

  // Responses pass through combinationally to the current owner only; a
  // pmem_resp in IDLE or D_HOLD reaches nobody.
  assign bus.i_pmem_resp  = bus.pmem_resp & (state == I_BUSY);
  assign bus.d_pmem_resp  = bus.pmem_resp & (state == D_BUSY);
  assign bus.i_pmem_rdata = bus.pmem_rdata;
  assign bus.d_pmem_rdata = bus.pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: directed stimulus for pmem_arbiter with a scoreboard.
// Stimulus pushes the expected memory-port transactions and the expected
// cache responses into queues; a negedge monitor pops and compares whenever
// a new memory strobe starts or a cache response is asserted.
module tb_pmem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pmem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } strb_t;

  typedef struct {
    logic              to_d;
    logic [LINE_W-1:0] rdata;
  } resp_t;

  strb_t exp_strb[$];
  resp_t exp_resp[$];
  logic  prev_strobe = 1'b0;

  task automatic chk(input string name, input logic [LINE_W-1:0] act,
                     input logic [LINE_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic exp_s(input logic wr, input logic [ADDR_W-1:0] addr,
                       input logic [LINE_W-1:0] wdata);
    strb_t s;
    s.wr = wr; s.addr = addr; s.wdata = wdata;
    exp_strb.push_back(s);
  endtask

  task automatic exp_r(input logic to_d, input logic [LINE_W-1:0] rdata);
    resp_t r;
    r.to_d = to_d; r.rdata = rdata;
    exp_resp.push_back(r);
  endtask

  // Monitor: compares each new strobe and each cache response with the queues.
  always @(negedge clk) begin : monitor
    logic  strobe;
    strb_t es;
    resp_t er;
    strobe = bus.pmem_read | bus.pmem_write;
    if (strobe && !prev_strobe) begin
      if (exp_strb.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL strobe_unexpected: got wr=%0b addr=%h, expected no strobe",
                 bus.pmem_write, bus.pmem_address);
      end else begin
        es = exp_strb.pop_front();
        chk("strobe_write", LINE_W'(bus.pmem_write), LINE_W'(es.wr));
        chk("strobe_read",  LINE_W'(bus.pmem_read),  LINE_W'(!es.wr));
        chk("strobe_addr",  LINE_W'(bus.pmem_address), LINE_W'(es.addr));
        if (es.wr) chk("strobe_wdata", bus.pmem_wdata, es.wdata);
      end
    end
    prev_strobe = strobe;

    if (bus.i_pmem_resp | bus.d_pmem_resp) begin
      if (exp_resp.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL resp_unexpected: got i=%0b d=%0b, expected no response",
                 bus.i_pmem_resp, bus.d_pmem_resp);
      end else begin
        er = exp_resp.pop_front();
        chk("resp_i", LINE_W'(bus.i_pmem_resp), LINE_W'(!er.to_d));
        chk("resp_d", LINE_W'(bus.d_pmem_resp), LINE_W'(er.to_d));
        chk("resp_rdata", er.to_d ? bus.d_pmem_rdata : bus.i_pmem_rdata, er.rdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_pmem_read    = 1'b0;
    bus.i_pmem_address = '0;
    bus.d_pmem_read    = 1'b0;
    bus.d_pmem_write   = 1'b0;
    bus.d_pmem_address = '0;
    bus.d_pmem_wdata   = '0;
    bus.pmem_rdata     = '0;
    bus.pmem_resp      = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Waits (bounded) for a memory strobe and checks how many cycles it took.
  task automatic wait_strobe(input string name, input int exp_lat);
    int lat;
    lat = 0;
    while (!(bus.pmem_read | bus.pmem_write) && lat < 20) begin
      tick();
      lat++;
    end
    chk(name, LINE_W'(lat), LINE_W'(exp_lat));
  endtask

  // One-cycle memory response; returns in the cycle after the response.
  task automatic respond(input logic [LINE_W-1:0] rdata);
    bus.pmem_rdata = rdata;
    bus.pmem_resp  = 1'b1;
    tick();
    bus.pmem_resp  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst_n = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_pmem_read",  LINE_W'(bus.pmem_read),    '0);
    chk("rst_pmem_write", LINE_W'(bus.pmem_write),   '0);
    chk("rst_pmem_addr",  LINE_W'(bus.pmem_address), '0);
    chk("rst_pmem_wdata", bus.pmem_wdata,            '0);
    chk("rst_i_resp",     LINE_W'(bus.i_pmem_resp),  '0);
    chk("rst_d_resp",     LINE_W'(bus.d_pmem_resp),  '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // T1: lone icache read, memory takes a few cycles
    exp_s(1'b0, 32'h0000_1000, '0);
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = 32'h0000_1000;
    wait_strobe("t1_grant_latency", 1);
    tick(); tick();
    chk("t1_read_held", LINE_W'(bus.pmem_read), LINE_W'(1'b1));
    exp_r(1'b0, {32{8'hAA}});
    respond({32{8'hAA}});
    bus.i_pmem_read = 1'b0;
    chk("t1_idle_read", LINE_W'(bus.pmem_read), '0);

    // T2: simultaneous requests after reset -> D first, then round-robin to I
    do_reset();
    exp_s(1'b0, 32'h0000_2100, '0);
    bus.d_pmem_wdata   = {32{8'hEE}};
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = 32'h0000_1100;
    bus.d_pmem_read    = 1'b1;
    bus.d_pmem_address = 32'h0000_2100;
    wait_strobe("t2_tie_d_latency", 1);
    exp_r(1'b1, {32{8'hBB}});
    respond({32{8'hBB}});
    bus.d_pmem_read = 1'b0;
    bus.i_pmem_read = 1'b0;
    tick();
    exp_s(1'b0, 32'h0000_1100, '0);
    bus.i_pmem_read = 1'b1;
    bus.d_pmem_read = 1'b1;
    wait_strobe("t2_tie_i_latency", 1);
    exp_r(1'b0, {32{8'h11}});
    respond({32{8'h11}});
    bus.i_pmem_read = 1'b0;
    exp_s(1'b0, 32'h0000_2100, '0);
    wait_strobe("t2_d_after_i", 1);
    exp_r(1'b1, {32{8'h22}});
    respond({32{8'h22}});
    bus.d_pmem_read = 1'b0;

    // T3: write-back then fill in D_HOLD while an icache read waits
    exp_s(1'b1, 32'h0000_2000, {32{8'h55}});
    bus.d_pmem_write   = 1'b1;
    bus.d_pmem_address = 32'h0000_2000;
    bus.d_pmem_wdata   = {32{8'h55}};
    wait_strobe("t3_wb_latency", 1);
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = 32'h0000_1000;
    exp_r(1'b1, {32{8'h77}});
    respond({32{8'h77}});
    chk("t3_hold_no_strobe", LINE_W'(bus.pmem_read | bus.pmem_write), '0);
    bus.d_pmem_write   = 1'b0;
    bus.d_pmem_read    = 1'b1;
    bus.d_pmem_address = 32'h0000_3000;
    exp_s(1'b0, 32'h0000_3000, '0);
    wait_strobe("t3_fill_latency", 1);
    exp_r(1'b1, {32{8'hCC}});
    respond({32{8'hCC}});
    bus.d_pmem_read = 1'b0;
    exp_s(1'b0, 32'h0000_1000, '0);
    wait_strobe("t3_i_after_fill", 1);
    exp_r(1'b0, {32{8'hDD}});
    respond({32{8'hDD}});
    bus.i_pmem_read = 1'b0;

    // T4: write-back with nothing from D in D_HOLD; waiting icache read follows
    exp_s(1'b1, 32'h0000_4000, {8{32'h1234_5678}});
    bus.d_pmem_write   = 1'b1;
    bus.d_pmem_address = 32'h0000_4000;
    bus.d_pmem_wdata   = {8{32'h1234_5678}};
    wait_strobe("t4_wb_latency", 1);
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = 32'h0000_5000;
    exp_r(1'b1, {32{8'h99}});
    respond({32{8'h99}});
    bus.d_pmem_write = 1'b0;
    chk("t4_hold_write_low", LINE_W'(bus.pmem_write), '0);
    exp_s(1'b0, 32'h0000_5000, '0);
    wait_strobe("t4_i_from_hold", 1);
    chk("t4_i_write_low", LINE_W'(bus.pmem_write), '0);
    exp_r(1'b0, {32{8'h66}});
    respond({32{8'h66}});
    bus.i_pmem_read = 1'b0;

    // T5: stray pmem_resp while idle
    tick();
    bus.pmem_rdata = {32{8'hF0}};
    bus.pmem_resp  = 1'b1;
    #1;
    chk("t5_stray_i_resp", LINE_W'(bus.i_pmem_resp), '0);
    chk("t5_stray_d_resp", LINE_W'(bus.d_pmem_resp), '0);
    chk("t5_stray_strobes", LINE_W'(bus.pmem_read | bus.pmem_write), '0);
    tick();
    bus.pmem_resp = 1'b0;
    chk("t5_after_strobes", LINE_W'(bus.pmem_read | bus.pmem_write), '0);

    // T6: asynchronous reset in the middle of a write-back
    exp_s(1'b1, 32'h0000_6000, {32{8'hA5}});
    bus.d_pmem_write   = 1'b1;
    bus.d_pmem_address = 32'h0000_6000;
    bus.d_pmem_wdata   = {32{8'hA5}};
    wait_strobe("t6_wb_latency", 1);
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = 32'h0000_7000;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_write_low", LINE_W'(bus.pmem_write), '0);
    chk("t6_async_addr",      LINE_W'(bus.pmem_address), '0);
    bus.d_pmem_write = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_released_idle", LINE_W'(bus.pmem_read | bus.pmem_write), '0);
    exp_s(1'b0, 32'h0000_7000, '0);
    wait_strobe("t6_i_after_reset", 1);
    exp_r(1'b0, {32{8'h3C}});
    respond({32{8'h3C}});
    bus.i_pmem_read = 1'b0;

    tick(); tick();
    chk("end_strobe_queue", LINE_W'(exp_strb.size()), '0);
    chk("end_resp_queue",   LINE_W'(exp_resp.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
